// File: rtl/cache_data_arbiter.sv
// cache_data_arbiter
// Controller and two-port arbiter for one cache data SRAM bank
// (2^IDX_W lines x LINE_W bits, active-low CEN/WEN/BWEN, registered read data).
// After reset it zero-fills the whole bank, then shares the single SRAM port
// between the CPU pipeline and the memory side, one access per cycle, and
// routes each read response back to the port that issued the read.
//
// Ports
//   clock, reset                 clock and asynchronous active-high reset
//   cpu_req_*                    CPU read / byte-masked store request (valid/ready)
//   cpu_resp_valid/rdata         CPU read data, one cycle after the grant
//   mem_req_*                    refill write / writeback read request (valid/ready)
//   mem_resp_valid/rdata         mem read data, one cycle after the grant
//   sram_cen_n/wen_n/a/bwen_n/d  SRAM macro controls and write data
//   sram_q                       SRAM read data, valid the cycle after a read
//
// State  | meaning
// -------+-----------------------------------------------------------
// INIT   | writing zeros to line init_cnt, both ready outputs held low
// RUN    | arbitrating CPU and mem requests onto the SRAM port
module cache_data_arbiter #(
    parameter int IDX_W      = 6,
    parameter int LINE_W     = 128,
    parameter int MAX_STREAK = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_wen,
    input  logic [IDX_W-1:0]      cpu_req_idx,
    input  logic [LINE_W-1:0]     cpu_req_wdata,
    input  logic [LINE_W/8-1:0]   cpu_req_wmask,
    output logic                  cpu_resp_valid,
    output logic [LINE_W-1:0]     cpu_resp_rdata,
    input  logic                  mem_req_valid,
    output logic                  mem_req_ready,
    input  logic                  mem_req_wen,
    input  logic [IDX_W-1:0]      mem_req_idx,
    input  logic [LINE_W-1:0]     mem_req_wdata,
    output logic                  mem_resp_valid,
    output logic [LINE_W-1:0]     mem_resp_rdata,
    output logic                  sram_cen_n,
    output logic                  sram_wen_n,
    output logic [IDX_W-1:0]      sram_a,
    output logic [LINE_W-1:0]     sram_bwen_n,
    output logic [LINE_W-1:0]     sram_d,
    input  logic [LINE_W-1:0]     sram_q
);

    localparam int MASK_W   = LINE_W / 8;
    localparam int STREAK_W = $clog2(MAX_STREAK + 1);
    localparam logic [IDX_W-1:0]    LAST_LINE  = '1;
    localparam logic [STREAK_W-1:0] STREAK_TOP = STREAK_W'(MAX_STREAK);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                state, state_next;
    logic [IDX_W-1:0]      init_cnt;
    logic [STREAK_W-1:0]   streak, streak_next;
    logic                  grant_cpu, grant_mem;
    logic                  resp_cpu, resp_mem;
    logic [LINE_W-1:0]     cpu_bwen_n;

    // Byte enables widened to the macro's per-bit write enables.
    for (genvar b = 0; b < MASK_W; b++) begin : g_bwen
        assign cpu_bwen_n[b*8 +: 8] = {8{~cpu_req_wmask[b]}};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            streak   <= '0;
            resp_cpu <= 1'b0;
            resp_mem <= 1'b0;
        end else begin
            state    <= state_next;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
            streak   <= streak_next;
            resp_cpu <= grant_cpu && !cpu_req_wen;
            resp_mem <= grant_mem && !mem_req_wen;
        end
    end

    always_comb begin
        state_next  = state;
        streak_next = streak;
        grant_cpu   = 1'b0;
        grant_mem   = 1'b0;
        sram_cen_n  = 1'b1;
        sram_wen_n  = 1'b1;
        sram_a      = '0;
        sram_bwen_n = '1;
        sram_d      = '0;

        case (state)
            ST_INIT: begin
                sram_cen_n  = 1'b0;
                sram_wen_n  = 1'b0;
                sram_a      = init_cnt;
                sram_bwen_n = '0;
                sram_d      = '0;
                if (init_cnt == LAST_LINE) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // The CPU wins outright unless mem is also asking, in which case
                // mem keeps the port until it has taken MAX_STREAK grants in a row.
                grant_cpu = cpu_req_valid && (!mem_req_valid || streak == STREAK_TOP);
                grant_mem = mem_req_valid && !grant_cpu;

                if (grant_cpu) begin
                    sram_cen_n = 1'b0;
                    sram_wen_n = ~cpu_req_wen;
                    sram_a     = cpu_req_idx;
                    if (cpu_req_wen) begin
                        sram_bwen_n = cpu_bwen_n;
                        sram_d      = cpu_req_wdata;
                    end
                end else if (grant_mem) begin
                    sram_cen_n = 1'b0;
                    sram_wen_n = ~mem_req_wen;
                    sram_a     = mem_req_idx;
                    if (mem_req_wen) begin
                        sram_bwen_n = '0;
                        sram_d      = mem_req_wdata;
                    end
                end

                if (!cpu_req_valid || grant_cpu) begin
                    streak_next = '0;
                end else if (grant_mem && streak != STREAK_TOP) begin
                    streak_next = streak + 1'b1;
                end
            end
            default: state_next = ST_INIT;
        endcase

        // Keep the macro deselected for the whole time reset is held.
        if (reset) begin
            sram_cen_n = 1'b1;
        end
    end

    assign cpu_req_ready  = grant_cpu;
    assign mem_req_ready  = grant_mem;
    assign cpu_resp_valid = resp_cpu;
    assign mem_resp_valid = resp_mem;
    assign cpu_resp_rdata = sram_q;
    assign mem_resp_rdata = sram_q;

endmodule

// File: tb/tb_cache_data_arbiter.sv
// tb_cache_data_arbiter
// Bench for cache_data_arbiter: a behavioural SRAM macro, a line-level
// reference model of the bank contents and the grant policy, and directed
// plus randomized scenarios each checked inline.
module tb_cache_data_arbiter;

    localparam int IDX_W      = 6;
    localparam int LINE_W     = 128;
    localparam int MAX_STREAK = 4;
    localparam int MW         = LINE_W / 8;
    localparam logic [LINE_W-1:0] PAT = 128'h0123456789ABCDEF0123456789ABCDEF;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_req_valid = 1'b0, cpu_req_wen = 1'b0;
    logic [IDX_W-1:0]  cpu_req_idx = '0;
    logic [LINE_W-1:0] cpu_req_wdata = '0;
    logic [MW-1:0]     cpu_req_wmask = '0;
    logic              mem_req_valid = 1'b0, mem_req_wen = 1'b0;
    logic [IDX_W-1:0]  mem_req_idx = '0;
    logic [LINE_W-1:0] mem_req_wdata = '0;
    logic              cpu_req_ready, mem_req_ready, cpu_resp_valid, mem_resp_valid;
    logic [LINE_W-1:0] cpu_resp_rdata, mem_resp_rdata;
    logic              sram_cen_n, sram_wen_n;
    logic [IDX_W-1:0]  sram_a;
    logic [LINE_W-1:0] sram_bwen_n, sram_d;
    logic [LINE_W-1:0] sram_q = '0;

    always #5 clock = ~clock;

    cache_data_arbiter #(.IDX_W(IDX_W), .LINE_W(LINE_W), .MAX_STREAK(MAX_STREAK)) dut (
        .clock(clock), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_wen(cpu_req_wen), .cpu_req_idx(cpu_req_idx),
        .cpu_req_wdata(cpu_req_wdata), .cpu_req_wmask(cpu_req_wmask),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_req_idx(mem_req_idx),
        .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .sram_cen_n(sram_cen_n), .sram_wen_n(sram_wen_n), .sram_a(sram_a),
        .sram_bwen_n(sram_bwen_n), .sram_d(sram_d), .sram_q(sram_q)
    );

    // SRAM macro model; while scramble is set it fills itself with garbage so
    // that the zero-fill after reset is actually observable.
    logic [LINE_W-1:0] sram_mem [2**IDX_W];
    logic              scramble = 1'b0;
    logic [IDX_W-1:0]  scr_idx = '0;

    always @(posedge clock) begin
        if (scramble) begin
            sram_mem[scr_idx] <= {$urandom, $urandom, $urandom, $urandom};
            scr_idx <= scr_idx + 1'b1;
        end else if (!sram_cen_n) begin
            if (!sram_wen_n)
                sram_mem[sram_a] <= (sram_mem[sram_a] & sram_bwen_n) | (sram_d & ~sram_bwen_n);
            else
                sram_q <= sram_mem[sram_a];
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference model: line contents and consecutive mem wins while the CPU waits.
    logic [LINE_W-1:0] ref_mem [2**IDX_W];
    int                m_wins = 0;

    logic              obs_crdy, obs_mrdy, obs_crv, obs_mrv;
    logic [LINE_W-1:0] obs_crd, obs_mrd;
    logic              exp_cg, exp_mg, exp_crv, exp_mrv;
    logic [LINE_W-1:0] exp_crd, exp_mrd;

    function automatic logic [LINE_W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2**IDX_W; i++) ref_mem[i] = '0;
        m_wins = 0;
    endtask

    // One RUN cycle: drive both ports, predict the outcome, record what the DUT
    // does (readies during the cycle, responses right after the edge).
    task automatic cycle(input logic cv, input logic cw, input logic [IDX_W-1:0] ci,
                         input logic [LINE_W-1:0] cd, input logic [MW-1:0] cm,
                         input logic mv, input logic mw, input logic [IDX_W-1:0] mi,
                         input logic [LINE_W-1:0] md);
        logic [LINE_W-1:0] line;
        cpu_req_valid = cv; cpu_req_wen = cw; cpu_req_idx = ci;
        cpu_req_wdata = cd; cpu_req_wmask = cm;
        mem_req_valid = mv; mem_req_wen = mw; mem_req_idx = mi; mem_req_wdata = md;
        exp_cg  = cv && (!mv || m_wins >= MAX_STREAK);
        exp_mg  = mv && !exp_cg;
        exp_crv = exp_cg && !cw;
        exp_mrv = exp_mg && !mw;
        exp_crd = ref_mem[ci];
        exp_mrd = ref_mem[mi];
        #1;
        obs_crdy = cpu_req_ready;
        obs_mrdy = mem_req_ready;
        @(posedge clock);
        if (exp_cg && cw) begin
            line = ref_mem[ci];
            for (int b = 0; b < MW; b++)
                if (cm[b]) line[b*8 +: 8] = cd[b*8 +: 8];
            ref_mem[ci] = line;
        end
        if (exp_mg && mw) ref_mem[mi] = md;
        if (!cv || exp_cg) m_wins = 0;
        else if (exp_mg) m_wins = m_wins + 1;
        #1;
        obs_crv = cpu_resp_valid; obs_crd = cpu_resp_rdata;
        obs_mrv = mem_resp_valid; obs_mrd = mem_resp_rdata;
        @(negedge clock);
    endtask

    task automatic test_reset();
        int lines [3] = '{0, 31, 63};
        reset = 1'b1; scramble = 1'b1;
        cpu_req_valid = 1'b1; cpu_req_wen = 1'b0; cpu_req_idx = '0;
        repeat (66) @(negedge clock);
        scramble = 1'b0;
        #1;
        total++;
        if ({sram_cen_n, cpu_req_ready, mem_req_ready, cpu_resp_valid, mem_resp_valid} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=10000",
                     {sram_cen_n, cpu_req_ready, mem_req_ready, cpu_resp_valid, mem_resp_valid});
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 2**IDX_W; i++) begin
            #1;
            total++;
            if ({cpu_req_ready, mem_req_ready} !== 2'b00) begin
                bad++; $display("FAIL init_ready cyc=%0d got=%b want=00", i, {cpu_req_ready, mem_req_ready});
            end
            total++;
            if ({sram_cen_n, sram_wen_n, sram_a, sram_bwen_n, sram_d} !== {2'b00, IDX_W'(i), {(2*LINE_W){1'b0}}}) begin
                bad++;
                $display("FAIL init_drive cyc=%0d got cen=%b wen=%b a=%0d bwen=%h d=%h want a=%0d zero write",
                         i, sram_cen_n, sram_wen_n, sram_a, sram_bwen_n, sram_d, i);
            end
            @(negedge clock);
        end
        model_clear();
        foreach (lines[k]) begin
            cycle(1'b1, 1'b0, IDX_W'(lines[k]), '0, '0, 1'b0, 1'b0, '0, '0);
            total++;
            if ({obs_crdy, obs_mrdy} !== 2'b10) begin
                bad++; $display("FAIL first_read_ready line=%0d got=%b want=10", lines[k], {obs_crdy, obs_mrdy});
            end
            total++;
            if ({obs_crv, obs_mrv} !== 2'b10 || obs_crd !== '0) begin
                bad++;
                $display("FAIL first_read_resp line=%0d got v=%b d=%h want v=10 d=0", lines[k], {obs_crv, obs_mrv}, obs_crd);
            end
        end
    endtask

    task automatic test_refill_read();
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 6'd5, PAT);
        total++;
        if ({obs_crdy, obs_mrdy, obs_crv, obs_mrv} !== 4'b0100) begin
            bad++; $display("FAIL refill_grant got=%b want=0100", {obs_crdy, obs_mrdy, obs_crv, obs_mrv});
        end
        cycle(1'b1, 1'b0, 6'd5, '0, '0, 1'b0, 1'b0, '0, '0);
        total++;
        if ({obs_crdy, obs_mrdy, obs_crv, obs_mrv} !== 4'b1010 || obs_crd !== PAT) begin
            bad++;
            $display("FAIL raw_read got=%b d=%h want=1010 d=%h", {obs_crdy, obs_mrdy, obs_crv, obs_mrv}, obs_crd, PAT);
        end
    endtask

    task automatic test_store_mask();
        logic [LINE_W-1:0] wd, want;
        wd = rnd128(); wd[7:0] = 8'hAA;
        want = PAT; want[7:0] = 8'hAA;
        cycle(1'b1, 1'b1, 6'd5, wd, 16'h0001, 1'b0, 1'b0, '0, '0);
        total++;
        if ({obs_crdy, obs_mrdy, obs_crv, obs_mrv} !== 4'b1000) begin
            bad++; $display("FAIL store_grant got=%b want=1000", {obs_crdy, obs_mrdy, obs_crv, obs_mrv});
        end
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 6'd5, '0);
        total++;
        if ({obs_crdy, obs_mrdy, obs_crv, obs_mrv} !== 4'b0101 || obs_mrd !== want) begin
            bad++;
            $display("FAIL store_byte0 got=%b d=%h want=0101 d=%h", {obs_crdy, obs_mrdy, obs_crv, obs_mrv}, obs_mrd, want);
        end
        cycle(1'b1, 1'b1, 6'd5, rnd128(), 16'h0000, 1'b0, 1'b0, '0, '0);
        total++;
        if ({obs_crdy, obs_mrdy, obs_crv, obs_mrv} !== 4'b1000) begin
            bad++; $display("FAIL nomask_grant got=%b want=1000", {obs_crdy, obs_mrdy, obs_crv, obs_mrv});
        end
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 6'd5, '0);
        total++;
        if (obs_mrv !== 1'b1 || obs_mrd !== want) begin
            bad++; $display("FAIL nomask_unchanged got v=%b d=%h want v=1 d=%h", obs_mrv, obs_mrd, want);
        end
    endtask

    task automatic test_back_to_back();
        logic [LINE_W-1:0] d1, d2;
        d1 = rnd128(); d2 = rnd128();
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 6'd1, d1);
        cycle(1'b1, 1'b1, 6'd2, d2, '1, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                cycle(1'b1, 1'b0, 6'd1, '0, '0, 1'b0, 1'b0, '0, '0);
                total++;
                if ({obs_crdy, obs_mrdy, obs_crv, obs_mrv} !== 4'b1010 || obs_crd !== d1) begin
                    bad++;
                    $display("FAIL b2b_cpu k=%0d got=%b d=%h want=1010 d=%h", k, {obs_crdy, obs_mrdy, obs_crv, obs_mrv}, obs_crd, d1);
                end
            end else begin
                cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 6'd2, '0);
                total++;
                if ({obs_crdy, obs_mrdy, obs_crv, obs_mrv} !== 4'b0101 || obs_mrd !== d2) begin
                    bad++;
                    $display("FAIL b2b_mem k=%0d got=%b d=%h want=0101 d=%h", k, {obs_crdy, obs_mrdy, obs_crv, obs_mrv}, obs_mrd, d2);
                end
            end
        end
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
        total++;
        if ({obs_crdy, obs_mrdy, obs_crv, obs_mrv} !== 4'b0000) begin
            bad++; $display("FAIL idle_after_b2b got=%b want=0000", {obs_crdy, obs_mrdy, obs_crv, obs_mrv});
        end
    endtask

    task automatic test_starvation();
        int mlines [5] = '{5, 1, 2, 5, 1};
        logic [LINE_W-1:0] want;
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 6'd2, '0);
        total++;
        if ({obs_crdy, obs_mrdy} !== 2'b01) begin
            bad++; $display("FAIL mem_alone got=%b want=01", {obs_crdy, obs_mrdy});
        end
        for (int k = 0; k < MAX_STREAK; k++) begin
            want = ref_mem[mlines[k]];
            cycle(1'b1, 1'b0, 6'd2, '0, '0, 1'b1, 1'b0, IDX_W'(mlines[k]), '0);
            total++;
            if ({obs_crdy, obs_mrdy, obs_mrv} !== 3'b011 || obs_mrd !== want) begin
                bad++;
                $display("FAIL streak_mem k=%0d got=%b d=%h want=011 d=%h", k, {obs_crdy, obs_mrdy, obs_mrv}, obs_mrd, want);
            end
        end
        want = ref_mem[2];
        cycle(1'b1, 1'b0, 6'd2, '0, '0, 1'b1, 1'b0, IDX_W'(mlines[4]), '0);
        total++;
        if ({obs_crdy, obs_mrdy, obs_crv, obs_mrv} !== 4'b1010 || obs_crd !== want) begin
            bad++;
            $display("FAIL starve_cpu_grant got=%b d=%h want=1010 d=%h", {obs_crdy, obs_mrdy, obs_crv, obs_mrv}, obs_crd, want);
        end
        cycle(1'b1, 1'b0, 6'd1, '0, '0, 1'b1, 1'b0, IDX_W'(mlines[4]), '0);
        total++;
        if ({obs_crdy, obs_mrdy} !== 2'b01) begin
            bad++; $display("FAIL streak_cleared got=%b want=01", {obs_crdy, obs_mrdy});
        end
        cycle(1'b1, 1'b0, 6'd1, '0, '0, 1'b0, 1'b0, '0, '0);
        total++;
        if ({obs_crdy, obs_mrdy} !== 2'b10) begin
            bad++; $display("FAIL cpu_after_streak got=%b want=10", {obs_crdy, obs_mrdy});
        end
    endtask

    task automatic test_random();
        logic cp = 1'b0, cw = 1'b0, mp = 1'b0, mw = 1'b0;
        logic [IDX_W-1:0]  ci = '0, mi = '0;
        logic [LINE_W-1:0] cd = '0, md = '0;
        logic [MW-1:0]     cm = '0;
        for (int n = 0; n < 400; n++) begin
            if (!cp && $urandom_range(0, 2) != 0) begin
                cp = 1'b1; cw = 1'($urandom_range(0, 1)); ci = IDX_W'($urandom_range(0, 7));
                cd = rnd128(); cm = ($urandom_range(0, 5) == 0) ? '0 : MW'($urandom);
            end
            if (!mp && $urandom_range(0, 3) != 0) begin
                mp = 1'b1; mw = 1'($urandom_range(0, 1)); mi = IDX_W'($urandom_range(0, 7));
                md = rnd128();
            end
            cycle(cp, cw, ci, cd, cm, mp, mw, mi, md);
            total++;
            if ({obs_crdy, obs_mrdy} !== {exp_cg, exp_mg}) begin
                bad++; $display("FAIL rand_grant n=%0d got=%b want=%b", n, {obs_crdy, obs_mrdy}, {exp_cg, exp_mg});
            end
            total++;
            if ({obs_crv, obs_mrv} !== {exp_crv, exp_mrv}) begin
                bad++; $display("FAIL rand_resp_valid n=%0d got=%b want=%b", n, {obs_crv, obs_mrv}, {exp_crv, exp_mrv});
            end
            if (exp_crv) begin
                total++;
                if (obs_crd !== exp_crd) begin
                    bad++; $display("FAIL rand_cpu_data n=%0d got=%h want=%h", n, obs_crd, exp_crd);
                end
            end
            if (exp_mrv) begin
                total++;
                if (obs_mrd !== exp_mrd) begin
                    bad++; $display("FAIL rand_mem_data n=%0d got=%h want=%h", n, obs_mrd, exp_mrd);
                end
            end
            if (exp_cg) cp = 1'b0;
            if (exp_mg) mp = 1'b0;
        end
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset_mid();
        cpu_req_valid = 1'b0;
        mem_req_valid = 1'b1; mem_req_wen = 1'b0; mem_req_idx = 6'd9;
        reset = 1'b1;
        #1;
        total++;
        if ({sram_cen_n, cpu_req_ready, mem_req_ready} !== 3'b100) begin
            bad++; $display("FAIL mid_reset_outputs got=%b want=100", {sram_cen_n, cpu_req_ready, mem_req_ready});
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            total++;
            if ({cpu_req_ready, mem_req_ready} !== 2'b00) begin
                bad++; $display("FAIL init1_ready cyc=%0d got=%b want=00", i, {cpu_req_ready, mem_req_ready});
            end
            @(negedge clock);
        end
        #1;
        total++;
        if (sram_a !== 6'd30) begin
            bad++; $display("FAIL init_line30 got=%0d want=30", sram_a);
        end
        reset = 1'b1;
        #1;
        total++;
        if (sram_cen_n !== 1'b1) begin
            bad++; $display("FAIL cen_in_reset got=%b want=1", sram_cen_n);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 2**IDX_W; i++) begin
            #1;
            total++;
            if ({cpu_req_ready, mem_req_ready, sram_a} !== {2'b00, IDX_W'(i)}) begin
                bad++;
                $display("FAIL init2 cyc=%0d got rdy=%b a=%0d want rdy=00 a=%0d", i, {cpu_req_ready, mem_req_ready}, sram_a, i);
            end
            @(negedge clock);
        end
        model_clear();
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 6'd9, '0);
        total++;
        if ({obs_crdy, obs_mrdy, obs_crv, obs_mrv} !== 4'b0101 || obs_mrd !== '0) begin
            bad++;
            $display("FAIL post_init2_read got=%b d=%h want=0101 d=0", {obs_crdy, obs_mrdy, obs_crv, obs_mrv}, obs_mrd);
        end
        cpu_req_valid = 1'b1; cpu_req_wen = 1'b0; cpu_req_idx = 6'd9; mem_req_valid = 1'b0;
        #1;
        total++;
        if (cpu_req_ready !== 1'b1) begin
            bad++; $display("FAIL drop_read_ready got=%b want=1", cpu_req_ready);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        cpu_req_valid = 1'b0;
        #1;
        total++;
        if ({cpu_resp_valid, mem_resp_valid, sram_cen_n} !== 3'b001) begin
            bad++; $display("FAIL drop_read_resp got=%b want=001", {cpu_resp_valid, mem_resp_valid, sram_cen_n});
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 2**IDX_W; i++) begin
            #1;
            total++;
            if ({cpu_req_ready, mem_req_ready, cpu_resp_valid, mem_resp_valid, sram_a} !== {4'b0000, IDX_W'(i)}) begin
                bad++;
                $display("FAIL init3 cyc=%0d got=%b a=%0d want=0000 a=%0d", i,
                         {cpu_req_ready, mem_req_ready, cpu_resp_valid, mem_resp_valid}, sram_a, i);
            end
            @(negedge clock);
        end
        model_clear();
        cycle(1'b1, 1'b0, 6'd9, '0, '0, 1'b0, 1'b0, '0, '0);
        total++;
        if ({obs_crdy, obs_mrdy, obs_crv, obs_mrv} !== 4'b1010 || obs_crd !== '0) begin
            bad++;
            $display("FAIL post_init3_read got=%b d=%h want=1010 d=0", {obs_crdy, obs_mrdy, obs_crv, obs_mrv}, obs_crd);
        end
    endtask

    initial begin
        test_reset();
        test_refill_read();
        test_store_mask();
        test_back_to_back();
        test_starvation();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
